// File: rtl/arbitro2_demux.sv
// Receive-side demux for the 4-channel weighted arbiter: pops the merged FIFO and routes each word by its 2-bit destination field.
// Optional weighted-sequence checker enabled by defining ARBITRO2_PATTERN_CHECK_EN.
module arbitro2_demux #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  emptyFIFO_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [3:0]            almost_fullFIFO,
    output logic                  pop_in,
    output logic [3:0]            push,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            state,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1,
    output logic [CNT_WIDTH-1:0]  cnt2,
    output logic [CNT_WIDTH-1:0]  cnt3,
    output logic                  err_pattern
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  valid_q;
    logic [1:0]            dest;
    logic [3:0]            push_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_WIDTH-1:0]  cnt_q [4];

    // Destination is unknown before the pop, so any almost_full blocks every channel.
    assign pop_in = ~reset & ~emptyFIFO_in & ~(|almost_fullFIFO);
    assign dest   = data_in[DATA_WIDTH-1 -: 2];

    // NOTE: combinational block assigns a default first so no path can infer a latch.
    always_comb begin
        state_d = ACTIVE;
        if (|almost_fullFIFO) begin
            state_d = STALL;
        end else if (emptyFIFO_in) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            push_q  <= 4'b0000;
            data_q  <= '0;
            state_q <= IDLE;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q <= pop_in;
            state_q <= state_d;
            if (valid_q) begin
                push_q       <= 4'b0001 << dest;
                data_q       <= data_in;
                cnt_q[dest]  <= cnt_q[dest] + CNT_WIDTH'(1);
            end else begin
                push_q <= 4'b0000;
            end
        end
    end

    assign push     = push_q;
    assign data_out = data_q;
    assign state    = state_q;
    assign cnt0     = cnt_q[0];
    assign cnt1     = cnt_q[1];
    assign cnt2     = cnt_q[2];
    assign cnt3     = cnt_q[3];

`ifdef ARBITRO2_PATTERN_CHECK_EN
    logic [3:0] pos_q;
    logic       err_q;
    logic [1:0] exp_dest;
    logic [3:0] resync_pos;

    // Expected order 0,0,0,0,1,1,1,2,2,3 mirrors the 4/3/2/1 arbiter weights.
    always_comb begin
        exp_dest = 2'd3;
        case (pos_q)
            4'd0, 4'd1, 4'd2, 4'd3: exp_dest = 2'd0;
            4'd4, 4'd5, 4'd6:       exp_dest = 2'd1;
            4'd7, 4'd8:             exp_dest = 2'd2;
            default:                exp_dest = 2'd3;
        endcase
    end

    always_comb begin
        resync_pos = 4'd0;
        case (dest)
            2'd0:    resync_pos = 4'd1;
            2'd1:    resync_pos = 4'd5;
            2'd2:    resync_pos = 4'd8;
            default: resync_pos = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= 4'd0;
            err_q <= 1'b0;
        end else if (valid_q) begin
            if (dest == exp_dest) begin
                pos_q <= (pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1;
            end else begin
                err_q <= 1'b1;
                pos_q <= resync_pos;
            end
        end
    end

    assign err_pattern = err_q;
`else
    assign err_pattern = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro2_demux.sv
// Directed testbench for arbitro2_demux; a small queue stands in for the merged input FIFO.
module tb_arbitro2_demux;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          emptyFIFO_in;
    logic [DW-1:0] data_in;
    logic [3:0]    almost_fullFIFO;
    logic          pop_in;
    logic [3:0]    push;
    logic [DW-1:0] data_out;
    logic [1:0]    state;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
    logic          err_pattern;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q [$];

    arbitro2_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .emptyFIFO_in(emptyFIFO_in), .data_in(data_in),
        .almost_fullFIFO(almost_fullFIFO), .pop_in(pop_in), .push(push), .data_out(data_out),
        .state(state), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .err_pattern(err_pattern)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: the input FIFO model serves a pop seen before the edge, then outputs settle.
    task automatic tick();
        logic p;
        p = pop_in;
        @(posedge clk);
        #1;
        if (p && q.size() > 0) data_in = q.pop_front();
        emptyFIFO_in = (q.size() == 0);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w);
        q.push_back(w);
        emptyFIFO_in = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    logic [DW-1:0] burst [10];
    logic [1:0]    bdest [10];
    logic          exp_err;

    initial begin
        reset = 1'b1;
        emptyFIFO_in = 1'b1;
        data_in = '0;
        almost_fullFIFO = 4'b0000;
        bdest = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        for (int i = 0; i < 10; i++) burst[i] = {bdest[i], 4'(i + 3)};
`ifdef ARBITRO2_PATTERN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // Reset held two cycles with a word waiting in the input FIFO.
        #2;
        load(6'b10_0101);
        tick();
        tick();
        check("rst_pop", pop_in, 1'b0);
        check("rst_push", push, 4'b0000);
        check("rst_data", data_out, 6'h00);
        check("rst_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'h0);
        check("rst_state", state, 2'd0);
        check("rst_err", err_pattern, 1'b0);

        // Single word: pop in N, push in N+2.
        reset = 1'b0;
        #1;
        check("single_pop_N", pop_in, 1'b1);
        tick();
        check("single_pop_N1", pop_in, 1'b0);
        check("single_push_N1", push, 4'b0000);
        tick();
        check("single_push_N2", push, 4'b0100);
        check("single_data_N2", data_out, 6'h25);
        check("single_cnt2", cnt2, 8'd1);
        tick();
        check("single_push_N3", push, 4'b0000);
        check("single_data_hold", data_out, 6'h25);

        // Ten-word weighted burst.
        do_reset();
        for (int i = 0; i < 10; i++) q.push_back(burst[i]);
        emptyFIFO_in = 1'b0;
        #1;
        check("burst_state_c0", state, 2'd0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c >= 2 && c <= 11) begin
                check($sformatf("burst_push_%0d", c), push, 4'b0001 << bdest[c-2]);
                check($sformatf("burst_data_%0d", c), data_out, burst[c-2]);
            end else begin
                check($sformatf("burst_push_%0d", c), push, 4'b0000);
            end
            if (c <= 10) check($sformatf("burst_state_%0d", c), state, 2'd1);
            else         check($sformatf("burst_state_%0d", c), state, 2'd0);
        end
        check("burst_cnts", {cnt0, cnt1, cnt2, cnt3}, {8'd4, 8'd3, 8'd2, 8'd1});
        check("burst_err", err_pattern, 1'b0);

        // Backpressure mid-burst: words popped in N-2, N-1 still deliver.
        do_reset();
        for (int i = 0; i < 6; i++) q.push_back({2'd1, 4'(i)});
        emptyFIFO_in = 1'b0;
        #1;
        tick();
        tick();
        almost_fullFIFO = 4'b0010;
        #1;
        check("af_pop_N", pop_in, 1'b0);
        check("af_push_N", push, 4'b0010);
        check("af_data_N", data_out, {2'd1, 4'd0});
        tick();
        check("af_pop_N1", pop_in, 1'b0);
        check("af_push_N1", push, 4'b0010);
        check("af_data_N1", data_out, {2'd1, 4'd1});
        check("af_state_N1", state, 2'd2);
        tick();
        check("af_push_N2", push, 4'b0000);
        check("af_state_N2", state, 2'd2);
        almost_fullFIFO = 4'b0000;
        #1;
        check("af_release_pop", pop_in, 1'b1);
        tick();
        check("af_state_release", state, 2'd1);
        tick();
        check("af_push_resume", push, 4'b0010);
        check("af_data_resume", data_out, {2'd1, 4'd2});
        for (int i = 0; i < 8; i++) tick();
        check("af_cnt1", cnt1, 8'd6);

        // Reset while a word is in flight.
        do_reset();
        load({2'd3, 4'hA});
        tick();
        reset = 1'b1;
        #1;
        tick();
        check("rstmid_push_edge", push, 4'b0000);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rstmid_push_%0d", i), push, 4'b0000);
        end
        check("rstmid_cnt3", cnt3, 8'd0);
        check("rstmid_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'h0);

        // 256 dest-0 words wrap cnt0.
        do_reset();
        for (int i = 0; i < 256; i++) q.push_back({2'd0, 4'(i)});
        emptyFIFO_in = 1'b0;
        #1;
        for (int c = 1; c <= 256; c++) tick();
        check("wrap_cnt0_255", cnt0, 8'd255);
        tick();
        check("wrap_cnt0_0", cnt0, 8'd0);
        check("wrap_push_last", push, 4'b0001);
        tick();
        check("wrap_push_idle", push, 4'b0000);

        // Destinations 0,0,1 break the weighted order on the third word.
        do_reset();
        load({2'd0, 4'h1});
        load({2'd0, 4'h2});
        load({2'd1, 4'h3});
        tick();
        tick();
        tick();
        check("pat_err_c3", err_pattern, 1'b0);
        tick();
        check("pat_push_c4", push, 4'b0010);
        check("pat_err_c4", err_pattern, exp_err);
        tick();
        tick();
        check("pat_err_sticky", err_pattern, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
